// File: rtl/silc_cmd_sequencer_pkg.sv
// Shared command codes, sequencer state encoding and byte-count helper for the SILC
// command sequencer.
package silc_cmd_sequencer_pkg;

  localparam logic [2:0] CmdNone  = 3'd0;
  localparam logic [2:0] CmdStart = 3'd1;
  localparam logic [2:0] CmdA     = 3'd2;
  localparam logic [2:0] CmdFinA  = 3'd3;
  localparam logic [2:0] CmdM     = 3'd4;
  localparam logic [2:0] CmdFin   = 3'd5;

  typedef enum logic [3:0] {
    SeqIdle,
    SeqStart,
    SeqWStart,
    SeqAdGet,
    SeqAdCmd,
    SeqWAd,
    SeqMGet,
    SeqMCmd,
    SeqWM,
    SeqCOut,
    SeqTOut,
    SeqErr
  } seq_state_e;

  // Byte counts above a full word saturate at 8.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] bytes);
    return (bytes > 4'd8) ? 4'd8 : bytes;
  endfunction

endpackage

// File: rtl/silc_pad64.sv
// Byte-count to 64-bit keep mask: the top `bytes` bytes (MSB-first) are ones, the rest zero.
module silc_pad64
  import silc_cmd_sequencer_pkg::*;
(
  input  logic [3:0]  bytes,
  output logic [63:0] mask
);

  logic [6:0] shamt;

  // A shift of 64 yields zero, so bytes=8 gives an all-ones mask.
  assign shamt = {clamp_bytes(bytes), 3'b000};
  assign mask  = ~({64{1'b1}} >> shamt);

endmodule

// File: rtl/silc_cmd_sequencer.sv
// Upstream driver for the SILC AEAD core: streams AD and message words into one-cycle command
// pulses, waits for core completion edges, and returns ciphertext words and the tag.
module silc_cmd_sequencer
  import silc_cmd_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned LEN_WIDTH    = 64,
  parameter int unsigned DONE_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ad_valid,
  output logic                 ad_ready,
  input  logic [WIDTH-1:0]     ad_data,
  input  logic                 ad_last,
  input  logic [3:0]           ad_bytes,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  input  logic [WIDTH-1:0]     msg_data,
  input  logic                 msg_last,
  input  logic [3:0]           msg_bytes,
  output logic [2:0]           core_cmd,
  output logic [WIDTH-1:0]     core_A,
  output logic [WIDTH-1:0]     core_M,
  output logic [LEN_WIDTH-1:0] core_len_A,
  input  logic                 core_done,
  input  logic [WIDTH-1:0]     core_C,
  input  logic [WIDTH-1:0]     core_T,
  output logic                 c_valid,
  input  logic                 c_ready,
  output logic [WIDTH-1:0]     c_data,
  output logic [3:0]           c_bytes,
  output logic                 c_last,
  output logic                 t_valid,
  input  logic                 t_ready,
  output logic [WIDTH-1:0]     t_data,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int unsigned CntW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DONE_TIMEOUT - 1);

  seq_state_e state_q, state_d;
  logic                 done_q, done_rise, in_wait;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           cmd_q, cmd_d;
  logic [WIDTH-1:0]     a_q, a_d, m_q, m_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 ad_last_q, ad_last_d, msg_last_q, msg_last_d;
  logic [3:0]           msg_bytes_q, msg_bytes_d;
  logic [WIDTH-1:0]     c_data_q, c_data_d, t_data_q, t_data_d;
  logic [3:0]           c_bytes_q, c_bytes_d;
  logic                 c_last_q, c_last_d;
  logic                 err_q, err_d;
  logic                 ad_ready_q, msg_ready_q, c_valid_q, t_valid_q, busy_q;
  logic [3:0]           ad_pad_bytes, msg_pad_bytes;
  logic [63:0]          ad_mask, msg_mask;

  assign done_rise = core_done & ~done_q;
  assign in_wait   = (state_q == SeqWStart) || (state_q == SeqWAd) || (state_q == SeqWM);

  // Non-last words are always full; a zero count on the last message word means full.
  assign ad_pad_bytes  = ad_last ? ad_bytes : 4'd8;
  assign msg_pad_bytes = (!msg_last || msg_bytes == 4'd0) ? 4'd8 : clamp_bytes(msg_bytes);

  silc_pad64 u_pad_ad (
    .bytes (ad_pad_bytes),
    .mask  (ad_mask)
  );

  silc_pad64 u_pad_msg (
    .bytes (msg_pad_bytes),
    .mask  (msg_mask)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    m_d         = m_q;
    len_d       = len_q;
    ad_last_d   = ad_last_q;
    msg_last_d  = msg_last_q;
    msg_bytes_d = msg_bytes_q;
    c_data_d    = c_data_q;
    c_bytes_d   = c_bytes_q;
    c_last_d    = c_last_q;
    t_data_d    = t_data_q;
    err_d       = err_q;

    unique case (state_q)
      SeqIdle, SeqErr: begin
        if (start) begin
          state_d = SeqStart;
          err_d   = 1'b0;
        end
      end
      SeqStart:  state_d = SeqWStart;
      SeqWStart: if (done_rise) state_d = SeqAdGet;
      SeqAdGet: begin
        if (ad_valid && ad_ready_q) begin
          a_d       = ad_data & ad_mask;
          len_d     = LEN_WIDTH'({clamp_bytes(ad_pad_bytes), 3'b000});
          ad_last_d = ad_last;
          state_d   = SeqAdCmd;
        end
      end
      SeqAdCmd: state_d = SeqWAd;
      SeqWAd:   if (done_rise) state_d = ad_last_q ? SeqMGet : SeqAdGet;
      SeqMGet: begin
        if (msg_valid && msg_ready_q) begin
          m_d         = msg_data & msg_mask;
          msg_last_d  = msg_last;
          msg_bytes_d = msg_pad_bytes;
          state_d     = SeqMCmd;
        end
      end
      SeqMCmd: state_d = SeqWM;
      SeqWM: begin
        if (done_rise) begin
          c_data_d  = core_C;
          c_bytes_d = msg_bytes_q;
          c_last_d  = msg_last_q;
          if (msg_last_q) t_data_d = core_T;
          state_d   = SeqCOut;
        end
      end
      SeqCOut: if (c_ready) state_d = c_last_q ? SeqTOut : SeqMGet;
      SeqTOut: if (t_ready) state_d = SeqIdle;
      default: state_d = SeqIdle;
    endcase

    // Watchdog: a done edge on the final allowed cycle still wins over the timeout.
    if (in_wait && !done_rise) begin
      if (cnt_q == CntLast) begin
        state_d = SeqErr;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (!in_wait) cnt_d = '0;

    case (state_d)
      SeqStart: cmd_d = CmdStart;
      SeqAdCmd: cmd_d = ad_last_d ? CmdFinA : CmdA;
      SeqMCmd:  cmd_d = msg_last_d ? CmdFin : CmdM;
      default:  cmd_d = CmdNone;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SeqIdle;
      done_q      <= 1'b1;
      cnt_q       <= '0;
      cmd_q       <= CmdNone;
      a_q         <= '0;
      m_q         <= '0;
      len_q       <= '0;
      ad_last_q   <= 1'b0;
      msg_last_q  <= 1'b0;
      msg_bytes_q <= '0;
      c_data_q    <= '0;
      c_bytes_q   <= '0;
      c_last_q    <= 1'b0;
      t_data_q    <= '0;
      err_q       <= 1'b0;
      ad_ready_q  <= 1'b0;
      msg_ready_q <= 1'b0;
      c_valid_q   <= 1'b0;
      t_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= core_done;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      m_q         <= m_d;
      len_q       <= len_d;
      ad_last_q   <= ad_last_d;
      msg_last_q  <= msg_last_d;
      msg_bytes_q <= msg_bytes_d;
      c_data_q    <= c_data_d;
      c_bytes_q   <= c_bytes_d;
      c_last_q    <= c_last_d;
      t_data_q    <= t_data_d;
      err_q       <= err_d;
      ad_ready_q  <= (state_d == SeqAdGet);
      msg_ready_q <= (state_d == SeqMGet);
      c_valid_q   <= (state_d == SeqCOut);
      t_valid_q   <= (state_d == SeqTOut);
      busy_q      <= (state_d != SeqIdle);
    end
  end

  assign core_cmd    = cmd_q;
  assign core_A      = a_q;
  assign core_M      = m_q;
  assign core_len_A  = len_q;
  assign ad_ready    = ad_ready_q;
  assign msg_ready   = msg_ready_q;
  assign c_valid     = c_valid_q;
  assign c_data      = c_data_q;
  assign c_bytes     = c_bytes_q;
  assign c_last      = c_last_q;
  assign t_valid     = t_valid_q;
  assign t_data      = t_data_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_silc_cmd_sequencer.sv
// Directed bench for silc_cmd_sequencer; the bench plays the core by hand.
module tb_silc_cmd_sequencer;
  import silc_cmd_sequencer_pkg::*;

  logic        clk, rst, start;
  logic        ad_valid, ad_ready, ad_last;
  logic [63:0] ad_data;
  logic [3:0]  ad_bytes;
  logic        msg_valid, msg_ready, msg_last;
  logic [63:0] msg_data;
  logic [3:0]  msg_bytes;
  logic [2:0]  core_cmd;
  logic [63:0] core_A, core_M, core_len_A, core_C, core_T;
  logic        core_done;
  logic        c_valid, c_ready, c_last, t_valid, t_ready, busy, err_timeout;
  logic [63:0] c_data, t_data;
  logic [3:0]  c_bytes;

  int n_vec = 0;
  int n_err = 0;

  silc_cmd_sequencer #(
    .WIDTH        (64),
    .LEN_WIDTH    (64),
    .DONE_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ad_valid    (ad_valid),
    .ad_ready    (ad_ready),
    .ad_data     (ad_data),
    .ad_last     (ad_last),
    .ad_bytes    (ad_bytes),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .msg_data    (msg_data),
    .msg_last    (msg_last),
    .msg_bytes   (msg_bytes),
    .core_cmd    (core_cmd),
    .core_A      (core_A),
    .core_M      (core_M),
    .core_len_A  (core_len_A),
    .core_done   (core_done),
    .core_C      (core_C),
    .core_T      (core_T),
    .c_valid     (c_valid),
    .c_ready     (c_ready),
    .c_data      (c_data),
    .c_bytes     (c_bytes),
    .c_last      (c_last),
    .t_valid     (t_valid),
    .t_ready     (t_ready),
    .t_data      (t_data),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks are entered and left on a negedge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_cmd", 64'(core_cmd), 64'(CmdStart));
    @(negedge clk);
    check("start_width", 64'(core_cmd), 64'(CmdNone));
  endtask

  task automatic done_pulse(input logic [63:0] c, input logic [63:0] t);
    core_C    = c;
    core_T    = t;
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic send_ad(input logic [63:0] d, input logic last, input logic [3:0] b);
    int n = 0;
    while (!ad_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ad_ready_seen", 64'(ad_ready), 64'd1);
    ad_valid = 1'b1;
    ad_data  = d;
    ad_last  = last;
    ad_bytes = b;
    @(negedge clk);
    ad_valid = 1'b0;
  endtask

  task automatic send_msg(input logic [63:0] d, input logic last, input logic [3:0] b);
    int n = 0;
    while (!msg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("msg_ready_seen", 64'(msg_ready), 64'd1);
    msg_valid = 1'b1;
    msg_data  = d;
    msg_last  = last;
    msg_bytes = b;
    @(negedge clk);
    msg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; core_done = 1'b1; core_C = '0; core_T = '0;
    ad_valid = 1'b0; ad_data = '0; ad_last = 1'b0; ad_bytes = '0;
    msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; msg_bytes = '0;
    c_ready = 1'b0; t_ready = 1'b0;
    repeat (2) @(negedge clk);

    // 1: reset state, done held high across reset exit, start pulse
    check("rst_cmd", 64'(core_cmd), 64'(CmdNone));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ad_ready", 64'(ad_ready), 64'd0);
    check("rst_c_valid", 64'(c_valid), 64'd0);
    check("rst_t_valid", 64'(t_valid), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    do_start();
    check("busy_after_start", 64'(busy), 64'd1);
    repeat (3) @(negedge clk);
    check("no_edge_level_done", 64'(ad_ready), 64'd0);
    core_done = 1'b0;
    @(negedge clk);
    done_pulse('0, '0);

    // 2: AD stream, full word then 4-byte last word
    send_ad(64'h0, 1'b0, 4'd8);
    check("ad0_cmd", 64'(core_cmd), 64'(CmdA));
    check("ad0_A", core_A, 64'h0);
    check("ad0_len", core_len_A, 64'd64);
    @(negedge clk);
    check("ad0_pulse_width", 64'(core_cmd), 64'(CmdNone));
    done_pulse('0, '0);
    send_ad({32'h1, 32'hFFFF_FFFF}, 1'b1, 4'd4);
    check("ad1_cmd", 64'(core_cmd), 64'(CmdFinA));
    check("ad1_A", core_A, {32'h1, 32'h0});
    check("ad1_len", core_len_A, 64'd32);
    @(negedge clk);
    done_pulse('0, '0);
    check("m_get_ad_ready", 64'(ad_ready), 64'd0);

    // 3: message stream with ciphertext and tag return
    send_msg(64'hfedc_ba09_8765_4321, 1'b0, 4'd8);
    check("m0_cmd", 64'(core_cmd), 64'(CmdM));
    check("m0_M", core_M, 64'hfedc_ba09_8765_4321);
    @(negedge clk);
    done_pulse(64'h0123_4567_89ab_cdef, 64'h0);
    check("c0_valid", 64'(c_valid), 64'd1);
    check("c0_data", c_data, 64'h0123_4567_89ab_cdef);
    check("c0_bytes", 64'(c_bytes), 64'd8);
    check("c0_last", 64'(c_last), 64'd0);
    c_ready = 1'b1;
    @(negedge clk);
    c_ready = 1'b0;
    check("c0_drop", 64'(c_valid), 64'd0);
    send_msg(64'h1, 1'b1, 4'd8);
    check("m1_cmd", 64'(core_cmd), 64'(CmdFin));
    check("m1_M", core_M, 64'h1);
    @(negedge clk);
    done_pulse(64'h5555_aaaa_1234_0001, 64'h7777_0000_beef_cafe);
    check("c1_data", c_data, 64'h5555_aaaa_1234_0001);
    check("c1_last", 64'(c_last), 64'd1);
    c_ready = 1'b1;
    @(negedge clk);
    c_ready = 1'b0;
    check("t_valid", 64'(t_valid), 64'd1);
    check("t_data", t_data, 64'h7777_0000_beef_cafe);
    t_ready = 1'b1;
    @(negedge clk);
    t_ready = 1'b0;
    check("msg1_idle", 64'(busy), 64'd0);

    // 4: empty AD, message offered early must wait
    do_start();
    done_pulse('0, '0);
    msg_valid = 1'b1;
    msg_data  = 64'h0bad_0bad_0bad_0bad;
    msg_last  = 1'b0;
    check("early_msg_ready", 64'(msg_ready), 64'd0);
    send_ad(64'hdead_beef_dead_beef, 1'b1, 4'd0);
    check("empty_cmd", 64'(core_cmd), 64'(CmdFinA));
    check("empty_A", core_A, 64'h0);
    check("empty_len", core_len_A, 64'd0);
    @(negedge clk);
    check("w_ad_msg_ready", 64'(msg_ready), 64'd0);
    @(negedge clk);
    check("w_ad_msg_ready2", 64'(msg_ready), 64'd0);
    done_pulse('0, '0);
    send_msg(64'h0bad_0bad_0bad_0bad, 1'b0, 4'd0);
    check("m2_cmd", 64'(core_cmd), 64'(CmdM));
    @(negedge clk);
    done_pulse(64'hc4c4_c4c4_c4c4_c4c4, 64'h0);

    // 5: ciphertext back-pressure for 20 cycles
    msg_valid = 1'b1;
    msg_data  = 64'h1122_3344_5566_7788;
    msg_last  = 1'b1;
    msg_bytes = 4'd3;
    for (int i = 0; i < 20; i++) begin
      check("stall_msg_ready", 64'(msg_ready), 64'd0);
      check("stall_c_data", c_data, 64'hc4c4_c4c4_c4c4_c4c4);
      check("stall_cmd", 64'(core_cmd), 64'(CmdNone));
      @(negedge clk);
    end
    c_ready = 1'b1;
    @(negedge clk);
    c_ready   = 1'b0;
    msg_valid = 1'b0;
    send_msg(64'h1122_3344_5566_7788, 1'b1, 4'd3);
    check("m3_cmd", 64'(core_cmd), 64'(CmdFin));
    check("m3_pad", core_M, 64'h1122_3300_0000_0000);
    @(negedge clk);
    done_pulse(64'hc5c5_c5c5_c5c5_c5c5, 64'h7a7a_7a7a_7a7a_7a7a);
    check("c3_bytes", 64'(c_bytes), 64'd3);
    check("c3_last", 64'(c_last), 64'd1);
    c_ready = 1'b1;
    @(negedge clk);
    c_ready = 1'b0;
    check("t3_data", t_data, 64'h7a7a_7a7a_7a7a_7a7a);
    t_ready = 1'b1;
    @(negedge clk);
    t_ready = 1'b0;

    // 6: stuck done after CMD_M, recovery by start, then async reset mid-W_AD
    do_start();
    done_pulse('0, '0);
    send_ad(64'ha5a5_a5a5_a5a5_a5a5, 1'b1, 4'd8);
    check("ad6_len", core_len_A, 64'd64);
    check("ad6_A", core_A, 64'ha5a5_a5a5_a5a5_a5a5);
    @(negedge clk);
    done_pulse('0, '0);
    send_msg(64'h6666_6666_6666_6666, 1'b0, 4'd8);
    check("m6_cmd", 64'(core_cmd), 64'(CmdM));
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check("timeout_early", 64'(err_timeout), 64'd0);
    end
    @(negedge clk);
    check("timeout_err", 64'(err_timeout), 64'd1);
    check("err_busy", 64'(busy), 64'd1);
    check("err_msg_ready", 64'(msg_ready), 64'd0);
    check("err_cmd", 64'(core_cmd), 64'(CmdNone));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_cmd", 64'(core_cmd), 64'(CmdStart));
    check("restart_err_clr", 64'(err_timeout), 64'd0);
    @(negedge clk);
    done_pulse('0, '0);
    send_ad(64'h1, 1'b0, 4'd8);
    check("ad7_cmd", 64'(core_cmd), 64'(CmdA));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_A", core_A, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_cmd", 64'(core_cmd), 64'(CmdNone));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
